pk_status_tx: RTL
=================

Name: pk_status_tx

Overview:
- Schedules the serial UART transmitter for the control panel and sends the panel state (W bus, indicator LEDs, P/MC flags, rotary position) to the host as a fixed 6-byte frame.
- Combines two frame triggers, an on-demand request (rx command group 3'b110) and a periodic auto-refresh timer, into a single frame stream.
- Drives the uart transmit byte/strobe and handshakes on tx_busy.
- Sits between the panel command decoder and the uart instance.

Parameters:
- PERIOD, 24'd500_000: auto-refresh interval in clk cycles (10 ms at 50 MHz). Must be at least 1.
- ACK_TIMEOUT, 8'd16: maximum cycles to wait for tx_busy to rise after a send strobe.

Ports:
- clk  in  1  system clock (50 MHz)
- rst_  in  1  asynchronous active-low reset
- req  in  1  one-cycle frame request from the command decoder
- auto_en  in  1  level; enables periodic frames
- w  in  16  W bus, bit order [0:15]
- leds  in  8  indicator LED vector
- p  in  1  P flag, active high
- mc  in  1  MC flag, active high
- rot  in  4  rotary position code (same encoding as the rx rotary command)
- tx_busy  in  1  uart transmitter busy
- tx_byte  out  8  byte to transmit
- tx_send  out  1  one-cycle transmit strobe
- busy  out  1  high while a frame is in progress
- frame_done  out  1  one-cycle pulse after the last byte completes
- tx_err  out  1  sticky; set when an ACK_TIMEOUT expires

Behaviour:
- Reset (rst_ low, asynchronous):
  - tx_byte=0, tx_send=0, busy=0, frame_done=0, tx_err=0.
  - State IDLE, pending=0, byte index=0, timer=PERIOD-1.
  - Reset during a frame aborts it immediately. No further strobes are issued after reset.
- Pending flag (single bit; requests coalesce):
  - Set by req=1, or by the timer expiring.
  - Cleared in the cycle a frame starts (IDLE->LOAD).
  - A req or timer expiry in that same cycle leaves pending=1, so exactly one further frame follows.
  - Any number of triggers during a frame produce at most one follow-up frame.
- Timer:
  - While auto_en=1, counts down every cycle.
  - At 0 it sets pending and reloads PERIOD-1.
  - While auto_en=0, it is held at PERIOD-1.
  - The timer runs independently of frame activity.
- Frame format (the snapshot is taken in LOAD; later input changes do not affect the frame):
  - B0 = {3'b110, 1'b0, rot}
  - B1 = w[0:7]
  - B2 = w[8:15]
  - B3 = leds
  - B4 = {6'b0, p, mc}
  - B5 = B0^B1^B2^B3^B4
- State machine:
  - IDLE: if pending, go to LOAD.
  - LOAD: capture the snapshot, index=0, busy=1. Go to ISSUE.
  - ISSUE: wait for tx_busy=0. Then drive tx_byte=B[index] and tx_send=1 for exactly one cycle. Go to ACK.
  - ACK: tx_byte is held stable.
    - tx_busy=1: go to DRAIN.
    - Otherwise, count ACK_TIMEOUT cycles. On expiry set tx_err=1 and go to NEXT (the byte is treated as sent).
  - DRAIN: wait for tx_busy=0, then go to NEXT.
  - NEXT:
    - index<5: index+1, go to ISSUE.
    - index=5: frame_done=1 for one cycle, busy=0, go to IDLE.
- Latency and timing:
  - From req (idle, tx_busy=0) to the first tx_send: 3 cycles (req registered into pending, IDLE, LOAD, ISSUE strobe).
  - Minimum spacing between strobes is gated by the uart's busy period.
- tx_send is never asserted while tx_busy=1 or outside ISSUE.
- tx_err clears only on reset.
- Index and timer arithmetic is unsigned and wraps only via explicit reload. Index never exceeds 5.

Test Plan:
- Single frame, checksum:
  - Stimulus: rot=4'h9, w=16'h1234, leds=8'hA5, p=1, mc=0; pulse req; uart model busy 10 cycles per byte.
  - Required: bytes C9,12,34,A5,02,48 in order; one frame_done pulse; busy high for the whole frame.
- Snapshot stability: change w to 16'hFFFF after the first strobe -> B1/B2 still 12/34; the next frame carries FF/FF.
- Coalescing: 5 req pulses during a frame -> exactly one follow-up frame, then IDLE; no third frame.
- Periodic refresh:
  - PERIOD=200, auto_en=1, fast uart -> frame starts spaced 200 cycles apart.
  - auto_en=0 -> no further frames; timer reloads to 199.
- Timeout: tx_busy stuck 0 -> after ACK_TIMEOUT=16 cycles per byte, tx_err=1; all 6 strobes are issued and frame_done fires.
- Reset mid-frame: assert rst_ after the 3rd strobe -> all outputs 0 asynchronously; no strobes until a new req after release; the next frame is complete and correct.

Source files
------------

// File: rtl/pk_status_tx.sv
// Panel status transmitter: snapshots panel state into a 6-byte frame and feeds it to the uart
// one byte at a time, on host request or on a periodic auto-refresh timer.
module pk_status_tx #(
    parameter logic [23:0] PERIOD      = 24'd500_000,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd16
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        req,
    input  logic        auto_en,
    input  logic [15:0] w,
    input  logic [7:0]  leds,
    input  logic        p,
    input  logic        mc,
    input  logic [3:0]  rot,
    input  logic        tx_busy,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    output logic        busy,
    output logic        frame_done,
    output logic        tx_err
);

    localparam int unsigned TMR_W     = 24;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ACK_W     = 8;
    localparam int unsigned NUM_BYTES = 6;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
    localparam logic [TMR_W-1:0] RELOAD   = PERIOD - TMR_W'(1);
    localparam logic [2:0]       GRP_STAT = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_ACK,
        S_DRAIN,
        S_NEXT
    } state_t;

    typedef logic [NUM_BYTES-1:0][BYTE_W-1:0] frame_t;

    state_t              state_q, state_d;
    logic                pending_q, pending_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ACK_W-1:0]    ack_cnt_q, ack_cnt_d;
    frame_t              frame_q, frame_d;
    frame_t              snap_c;
    logic [BYTE_W-1:0]   tx_byte_d;
    logic                tx_send_d;
    logic                busy_d;
    logic                frame_done_d;
    logic                tx_err_d;
    logic                tmr_exp_c;
    logic                ack_expire_c;

    function automatic logic [BYTE_W-1:0] byte_at(input frame_t f, input logic [IDX_W-1:0] i);
        logic [BYTE_W-1:0] b;
        case (i)
            3'd0:    b = f[0];
            3'd1:    b = f[1];
            3'd2:    b = f[2];
            3'd3:    b = f[3];
            3'd4:    b = f[4];
            3'd5:    b = f[5];
            default: b = '0;
        endcase
        return b;
    endfunction

    // Frame image built from the live inputs; w is numbered [0:15] MSB-first on the panel
    always_comb begin
        snap_c    = '0;
        snap_c[0] = {GRP_STAT, 1'b0, rot};
        snap_c[1] = w[15:8];
        snap_c[2] = w[7:0];
        snap_c[3] = leds;
        snap_c[4] = {6'b0, p, mc};
        snap_c[5] = snap_c[0] ^ snap_c[1] ^ snap_c[2] ^ snap_c[3] ^ snap_c[4];
    end

    // Auto-refresh timer and the coalescing pending flag
    always_comb begin
        tmr_exp_c = auto_en && (timer_q == '0);
        timer_d   = timer_q;
        if (!auto_en || (timer_q == '0)) begin
            timer_d = RELOAD;
        end else begin
            timer_d = timer_q - TMR_W'(1);
        end
        pending_d = req || tmr_exp_c || (pending_q && (state_q != S_IDLE));
    end

    assign ack_expire_c = (state_q == S_ACK) && !tx_busy &&
                          (({1'b0, ack_cnt_q} + 9'd1) >= {1'b0, ACK_TIMEOUT});

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pending_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (tx_send) state_d = S_ACK;
            end
            S_ACK: begin
                if (tx_busy) begin
                    state_d = S_DRAIN;
                end else if (ack_expire_c) begin
                    state_d = S_NEXT;
                end
            end
            S_DRAIN: begin
                if (!tx_busy) state_d = S_NEXT;
            end
            S_NEXT: begin
                state_d = (idx_q == LAST_IDX) ? S_IDLE : S_ISSUE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs are computed from the upcoming state so the strobe lands inside ISSUE
    always_comb begin
        frame_d      = frame_q;
        idx_d        = idx_q;
        ack_cnt_d    = '0;
        tx_byte_d    = tx_byte;
        tx_err_d     = tx_err || ack_expire_c;
        busy_d       = (state_d != S_IDLE);
        frame_done_d = (state_q == S_NEXT) && (idx_q == LAST_IDX);
        tx_send_d    = (state_d == S_ISSUE) && !tx_busy;

        if (state_q == S_LOAD) begin
            frame_d = snap_c;
            idx_d   = '0;
        end
        if ((state_q == S_NEXT) && (idx_q != LAST_IDX)) begin
            idx_d = idx_q + IDX_W'(1);
        end
        if ((state_q == S_ACK) && !tx_busy && !ack_expire_c) begin
            ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
        if (tx_send_d) begin
            tx_byte_d = byte_at(frame_d, idx_d);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pending_q  <= 1'b0;
            timer_q    <= RELOAD;
            idx_q      <= '0;
            ack_cnt_q  <= '0;
            frame_q    <= '0;
            tx_byte    <= '0;
            tx_send    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            timer_q    <= timer_d;
            idx_q      <= idx_d;
            ack_cnt_q  <= ack_cnt_d;
            frame_q    <= frame_d;
            tx_byte    <= tx_byte_d;
            tx_send    <= tx_send_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            tx_err     <= tx_err_d;
        end
    end

endmodule
